prod_accum: RTL
===============

// Module: prod_accum
// PURPOSE
//  Downstream consumer of the 4-bit sequential multiplier's 8-bit product.
//  Sums a block of BLOCK_LEN consecutive products into a wider accumulator.
//  Presents the finished sum to the next stage with a valid/ready handshake.
//  Together with the multiplier, this forms a dot-product / MAC datapath.
// PARAMETERS
//  PROD_W     8   product width; matches the multiplier output op
//  ACC_W      16  accumulator width; must satisfy ACC_W >= PROD_W
//  BLOCK_LEN  4   products per block; must be >= 1
// PORTS
//  clk        in   1       rising-edge clock
//  rst_a      in   1       synchronous, active-high reset
//  start      in   1       1-cycle pulse; opens a new block
//  prod_in    in   PROD_W  product from multiplier (op)
//  prod_vld   in   1       each high cycle = one new product on prod_in
//  acc_out    out  ACC_W   block sum; valid while acc_vld=1
//  acc_vld    out  1       sum available
//  acc_rdy    in   1       downstream accepts sum when acc_vld&acc_rdy
//  busy       out  1       high in ACC state
//  ovf        out  1       sticky: block sum exceeded 2^ACC_W-1
//  drop       out  1       1-cycle pulse: prod_vld ignored (IDLE/HOLD)
// BEHAVIOUR
//  - All state updates at posedge clk.
//  - rst_a=1 wins over all inputs: state=IDLE, acc_out=0, acc_vld=0, busy=0,
//    ovf=0, drop=0, count=0. A reset mid-block discards the partial sum.
//  - FSM:
//    - IDLE: start=1 -> ACC; clears acc, count, ovf.
//    - ACC: busy=1. Each prod_vld: acc += zero-extended prod_in; count++.
//      The BLOCK_LEN-th accepted product -> HOLD. start in ACC is ignored.
//    - HOLD: acc_vld=1; acc_out is stable and ovf stays valid.
//      - acc_rdy=1 & start=0 -> IDLE.
//      - acc_rdy=1 & start=1 -> ACC directly; clears acc, count, ovf.
//      - acc_rdy=0 -> stay in HOLD; start is ignored.
//  - Latency: acc_vld rises the cycle after the last product is sampled.
//  - Throughput: one product per cycle. No gaps are required between
//    prod_vld pulses.
//  - prod_vld in IDLE or HOLD: product not summed; drop=1 for that next cycle.
//  - Arithmetic: unsigned. Default mode wraps modulo 2^ACC_W. ovf is set on
//    any carry out of bit ACC_W-1 and holds until the next block start.
//  - The counter is $clog2(BLOCK_LEN+1) bits. BLOCK_LEN=1 gives ACC->HOLD
//    after a single product.
// CONFIGURATION
//  PROD_ACCUM_SAT_EN defined: on a carry out, acc saturates at {ACC_W{1'b1}}
//    and remains there for the rest of the block; ovf is set as usual.
//  PROD_ACCUM_SAT_EN undefined: wrap-around as described above.
// TESTING
//  1. Reset, start, 4x prod_vld with prod_in=225, acc_rdy=1
//     -> acc_out=900 (0x0384) with acc_vld for 1 cycle, ovf=0, then IDLE.
//  2. Same stimulus as 1 with acc_rdy=0 for 5 cycles
//     -> acc_vld/acc_out held at 900; extra prod_vld gives drop=1;
//        then acc_rdy=1 -> IDLE.
//  3. ACC_W=10, BLOCK_LEN=5, 5x prod_in=225
//     -> acc_out=101, ovf=1; with PROD_ACCUM_SAT_EN: acc_out=1023, ovf=1.
//  4. HOLD with acc_rdy=1 and start=1 in the same cycle
//     -> next cycle busy=1, acc=0, ovf=0; products 1,2,3,4 give acc_out=10.
//  5. rst_a=1 after 2 of 4 products -> all outputs 0; next block of 4x10
//     -> acc_out=40.
//  6. prod_vld asserted while IDLE (no start) -> drop pulses, acc_vld stays 0,
//     acc_out unchanged.

Source files
------------

// File: rtl/prod_accum.sv
// prod_accum
//   Sums blocks of BLOCK_LEN consecutive products coming from the 4-bit
//   sequential multiplier and hands each finished sum downstream with a
//   valid/ready handshake. Together with the multiplier it forms a MAC /
//   dot-product datapath.
//
//   Optional feature: define PROD_ACCUM_SAT_EN to make the accumulator
//   saturate at all-ones on overflow instead of wrapping modulo 2^ACC_W.
//
// Ports
//   clk       rising-edge clock
//   rst_a     synchronous active-high reset
//   start     1-cycle pulse that opens a new block (IDLE, or HOLD with acc_rdy)
//   prod_in   product from the multiplier
//   prod_vld  one new product on prod_in per high cycle
//   acc_out   block sum, valid while acc_vld=1
//   acc_vld   finished sum available
//   acc_rdy   downstream accepts the sum when acc_vld & acc_rdy
//   busy      high while accumulating
//   ovf       sticky carry-out flag for the current block
//   drop      1-cycle pulse: a product arrived in IDLE/HOLD and was ignored

module prod_accum #(
  parameter int PROD_W    = 8,
  parameter int ACC_W     = 16,
  parameter int BLOCK_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_a,
  input  logic              start,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_vld,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_vld,
  input  logic              acc_rdy,
  output logic              busy,
  output logic              ovf,
  output logic              drop
);

  localparam int CNT_W = $clog2(BLOCK_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [ACC_W:0]   sum;

  // One extra bit on the adder so the carry out of the accumulator is visible.
  always_comb begin
    sum = {1'b0, acc_out} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_in};
  end

  always_ff @(posedge clk) begin
    if (rst_a) begin
      state   <= IDLE;
      acc_out <= '0;
      acc_vld <= 1'b0;
      busy    <= 1'b0;
      ovf     <= 1'b0;
      drop    <= 1'b0;
      count   <= '0;
    end else begin
      // Products are only consumed while accumulating; flag the rest.
      drop <= prod_vld && (state != ACC);

      case (state)
        IDLE: begin
          if (start) begin
            state   <= ACC;
            busy    <= 1'b1;
            acc_out <= '0;
            count   <= '0;
            ovf     <= 1'b0;
          end
        end

        ACC: begin
          if (prod_vld) begin
`ifdef PROD_ACCUM_SAT_EN
            // Once saturated, stay pinned at all-ones until the next block.
            if (sum[ACC_W] || ovf) begin
              acc_out <= '1;
            end else begin
              acc_out <= sum[ACC_W-1:0];
            end
`else
            acc_out <= sum[ACC_W-1:0];
`endif
            ovf   <= ovf | sum[ACC_W];
            count <= count + CNT_W'(1);
            if (count == LAST_IDX) begin
              state   <= HOLD;
              busy    <= 1'b0;
              acc_vld <= 1'b1;
            end
          end
        end

        HOLD: begin
          // start is only honoured together with the handshake completing.
          if (acc_rdy) begin
            acc_vld <= 1'b0;
            if (start) begin
              state   <= ACC;
              busy    <= 1'b1;
              acc_out <= '0;
              count   <= '0;
              ovf     <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          acc_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule
